// File: rtl/lcd_bus_responder.sv
// HD44780-style responder on the far end of an 8-bit character-LCD bus.
// Keeps a shadow DDRAM, address counter and display state, models busy, answers reads.
module lcd_bus_responder #(
   parameter int BUSY_CYCLES  = 4,
   parameter int CLEAR_CYCLES = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] LCD,
   input  logic       lcdRS,
   input  logic       lcdRW,
   input  logic       lcdEn,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic [6:0] addr_cnt,
   output logic       disp_on,
   output logic       char_strobe,
   output logic [6:0] char_addr,
   output logic [7:0] char_data,
   output logic       cmd_err,
   input  logic [6:0] peek_addr,
   output logic [7:0] peek_data
);
   localparam int            DEPTH   = 80;
   localparam int            MAXC    = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int            CW      = $clog2(MAXC + 1);
   localparam logic [CW-1:0] BUSY_N  = CW'(BUSY_CYCLES);
   localparam logic [CW-1:0] CLEAR_N = CW'(CLEAR_CYCLES);
   localparam logic [6:0]    LAST    = 7'(DEPTH - 1);
   localparam logic [6:0]    DEPTH7  = 7'(DEPTH);
   localparam logic [7:0]    BLANK   = 8'h20;

   // Synchronizer word layout: {en, rs, rw, data[7:0]}
   logic [10:0]   s1_q;
   logic [10:0]   s2_q;
   logic          en_prev_q;
   logic          rs_h_q;
   logic          rw_h_q;
   logic [7:0]    data_h_q;
   logic          fall;

   logic [6:0]    ac_q, ac_d;
   logic          id_q, id_d;
   logic          disp_q, disp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          strobe_q, strobe_d;
   logic [6:0]    caddr_q, caddr_d;
   logic [7:0]    cdata_q, cdata_d;
   logic          mem_we;
   logic          mem_clr;
   logic [7:0]    mem_q [DEPTH];

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      if (inc) return (ac == LAST) ? 7'd0 : ac + 7'd1;
      return (ac == 7'd0) ? LAST : ac - 7'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         en_prev_q <= 1'b0;
         rs_h_q    <= 1'b0;
         rw_h_q    <= 1'b0;
         data_h_q  <= 8'h00;
      end else begin
         s1_q      <= {lcdEn, lcdRS, lcdRW, LCD};
         s2_q      <= s1_q;
         en_prev_q <= s2_q[10];
         // The fall acts on what the bus carried while En was last high.
         if (s2_q[10]) begin
            rs_h_q   <= s2_q[9];
            rw_h_q   <= s2_q[8];
            data_h_q <= s2_q[7:0];
         end
      end
   end

   assign fall = ~s2_q[10] & en_prev_q;
   assign busy = (cnt_q != '0);

   always_comb begin
      ac_d     = ac_q;
      id_d     = id_q;
      disp_d   = disp_q;
      err_d    = err_q;
      cnt_d    = busy ? cnt_q - 1'b1 : cnt_q;
      strobe_d = 1'b0;
      caddr_d  = caddr_q;
      cdata_d  = cdata_q;
      mem_we   = 1'b0;
      mem_clr  = 1'b0;
      if (fall) begin
         if (rw_h_q) begin
            if (rs_h_q) ac_d = ac_step(ac_q, id_q);
         end else if (busy) begin
            err_d = 1'b1;
         end else if (rs_h_q) begin
            mem_we   = 1'b1;
            strobe_d = 1'b1;
            caddr_d  = ac_q;
            cdata_d  = data_h_q;
            ac_d     = ac_step(ac_q, id_q);
            cnt_d    = BUSY_N;
         end else begin
            cnt_d = BUSY_N;
            casez (data_h_q)
               8'b1???????: ac_d = (data_h_q[6:0] < DEPTH7) ? data_h_q[6:0] : 7'd0;
               8'b0001????: if (!data_h_q[3]) ac_d = ac_step(ac_q, data_h_q[2]);
               8'b00001???: disp_d = data_h_q[2];
               8'b000001??: id_d = data_h_q[1];
               8'b0000001?: begin
                  ac_d  = 7'd0;
                  cnt_d = CLEAR_N;
               end
               8'b00000001: begin
                  mem_clr = 1'b1;
                  ac_d    = 7'd0;
                  id_d    = 1'b1;
                  cnt_d   = CLEAR_N;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ac_q     <= 7'd0;
         id_q     <= 1'b1;
         disp_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         strobe_q <= 1'b0;
         caddr_q  <= 7'd0;
         cdata_q  <= 8'h00;
      end else begin
         ac_q     <= ac_d;
         id_q     <= id_d;
         disp_q   <= disp_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         strobe_q <= strobe_d;
         caddr_q  <= caddr_d;
         cdata_q  <= cdata_d;
      end
   end

   // Register array rather than block RAM: clear must blank every byte in one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK;
      end else if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK;
      end else if (mem_we) begin
         mem_q[ac_q] <= data_h_q;
      end
   end

   assign rd_valid    = s2_q[10] & s2_q[8];
   assign rd_data     = s2_q[9] ? mem_q[ac_q] : {busy, ac_q};
   assign addr_cnt    = ac_q;
   assign disp_on     = disp_q;
   assign char_strobe = strobe_q;
   assign char_addr   = caddr_q;
   assign char_data   = cdata_q;
   assign cmd_err     = err_q;
   assign peek_data   = (peek_addr < DEPTH7) ? mem_q[peek_addr] : 8'h00;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: vector table, timing corner sequences,
// and randomized bus traffic against a transaction-level model of the LCD controller.
module tb_lcd_bus_responder;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] LCD = 8'h00;
   logic       lcdRS = 1'b0;
   logic       lcdRW = 1'b0;
   logic       lcdEn = 1'b0;
   logic [6:0] peek_addr = 7'd0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic [6:0] addr_cnt;
   logic       disp_on;
   logic       char_strobe;
   logic [6:0] char_addr;
   logic [7:0] char_data;
   logic       cmd_err;
   logic [7:0] peek_data;

   always #5 clk = ~clk;

   lcd_bus_responder #(.BUSY_CYCLES(4), .CLEAR_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .LCD(LCD), .lcdRS(lcdRS), .lcdRW(lcdRW), .lcdEn(lcdEn),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .addr_cnt(addr_cnt),
      .disp_on(disp_on), .char_strobe(char_strobe), .char_addr(char_addr),
      .char_data(char_data), .cmd_err(cmd_err), .peek_addr(peek_addr), .peek_data(peek_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0] m_mem [80];
   int         m_ac;
   logic       m_id;
   logic       m_disp;

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         ac;
      logic       disp;
      int         nbusy;
      int         pa;
      logic [7:0] pv;
   } vec_t;
   vec_t vt [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Leaves the bus at a negedge with En just lowered; E0 is the next posedge.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int lo,
                         output logic [7:0] rd, output logic rv);
      repeat (lo) @(negedge clk);
      lcdRS = rs; lcdRW = rw; LCD = d; lcdEn = 1'b1;
      repeat (3) @(negedge clk);
      rd = rd_data;
      rv = rd_valid;
      lcdEn = 1'b0;
      $display("[TB] bus rs=%0d rw=%0d d=0x%02h rd=0x%02h", rs, rw, d, rd);
   endtask

   task automatic wait_e2();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 300) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic peek(input int a, output logic [7:0] v);
      peek_addr = 7'(a);
      #1;
      v = peek_data;
   endtask

   task automatic check_blank(input string name);
      int bad;
      logic [7:0] v;
      bad = 0;
      for (int a = 0; a < 80; a++) begin
         peek(a, v);
         if (v !== 8'h20) bad++;
      end
      check(name, bad, 0);
   endtask

   task automatic op(input logic rs, input logic rw, input logic [7:0] d);
      logic [7:0] rdv;
      logic rv;
      int n;
      strobe(rs, rw, d, 3, rdv, rv);
      wait_e2();
      busy_len(n);
   endtask

   function automatic int adv(input int a, input logic inc);
      return inc ? (a + 1) % 80 : (a + 79) % 80;
   endfunction

   task automatic model_cmd(input logic [7:0] d, output int n);
      n = 4;
      if (d >= 8'h80) m_ac = (int'(d) - 128 < 80) ? int'(d) - 128 : 0;
      else if (d >= 8'h20) n = 4;
      else if (d >= 8'h10) begin
         if (!d[3]) m_ac = adv(m_ac, d[2]);
      end
      else if (d >= 8'h08) m_disp = d[2];
      else if (d >= 8'h04) m_id = d[1];
      else if (d >= 8'h02) begin
         m_ac = 0;
         n = 100;
      end
      else if (d == 8'h01) begin
         for (int a = 0; a < 80; a++) m_mem[a] = 8'h20;
         m_ac = 0;
         m_id = 1'b1;
         n = 100;
      end
   endtask

   function automatic logic [7:0] rnd_cmd();
      logic [7:0] r;
      r = 8'($urandom);
      case ($urandom_range(0, 8))
         0: return 8'h80 | r;
         1: return 8'h40 | (r & 8'h3F);
         2: return 8'h20 | (r & 8'h1F);
         3: return 8'h10 | (r & 8'h0F);
         4: return 8'h08 | (r & 8'h07);
         5: return 8'h04 | (r & 8'h03);
         6: return 8'h02 | (r & 8'h01);
         7: return ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic do_op(input logic rs, input logic rw, input logic [7:0] d);
      logic [7:0] rdv, exp_rd, v;
      logic rv;
      int n, old_ac, pa;
      old_ac = m_ac;
      exp_rd = rs ? m_mem[m_ac] : 8'(m_ac);
      n = 0;
      if (rw) begin
         if (rs) m_ac = adv(m_ac, m_id);
      end else if (rs) begin
         m_mem[m_ac] = d;
         m_ac = adv(m_ac, m_id);
         n = 4;
      end else begin
         model_cmd(d, n);
      end
      strobe(rs, rw, d, 3, rdv, rv);
      if (rw) begin
         check("rnd rd_valid", rv, 1);
         check("rnd rd_data", rdv, exp_rd);
      end
      wait_e2();
      check("rnd char_strobe", char_strobe, rs & ~rw);
      if (rs && !rw) begin
         check("rnd char_addr", char_addr, old_ac);
         check("rnd char_data", char_data, d);
      end
      repeat (n + 1) @(posedge clk);
      #1;
      check("rnd busy_done", busy, 0);
      check("rnd addr_cnt", addr_cnt, m_ac);
      check("rnd disp_on", disp_on, m_disp);
      check("rnd cmd_err", cmd_err, 0);
      pa = $urandom_range(0, 79);
      peek(pa, v);
      check("rnd peek", v, m_mem[pa]);
   endtask

   initial begin
      #500_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rdv, v;
      logic rv;
      int n, prev_ac, bad;

      vt[0]  = '{1'b0, 8'h0C, 0,  1'b1, 4,   0,  8'h20};
      vt[1]  = '{1'b1, 8'h41, 1,  1'b1, 4,   0,  8'h41};
      vt[2]  = '{1'b0, 8'hCF, 79, 1'b1, 4,   79, 8'h20};
      vt[3]  = '{1'b1, 8'h5A, 0,  1'b1, 4,   79, 8'h5A};
      vt[4]  = '{1'b0, 8'h04, 0,  1'b1, 4,   0,  8'h41};
      vt[5]  = '{1'b1, 8'h33, 79, 1'b1, 4,   0,  8'h33};
      vt[6]  = '{1'b0, 8'h06, 79, 1'b1, 4,   1,  8'h20};
      vt[7]  = '{1'b0, 8'h14, 0,  1'b1, 4,   79, 8'h5A};
      vt[8]  = '{1'b0, 8'h10, 79, 1'b1, 4,   0,  8'h33};
      vt[9]  = '{1'b0, 8'h1C, 79, 1'b1, 4,   1,  8'h20};
      vt[10] = '{1'b0, 8'hD0, 0,  1'b1, 4,   0,  8'h33};
      vt[11] = '{1'b0, 8'h08, 0,  1'b0, 4,   0,  8'h33};
      vt[12] = '{1'b0, 8'h93, 19, 1'b0, 4,   19, 8'h20};
      vt[13] = '{1'b0, 8'h02, 0,  1'b0, 100, 79, 8'h5A};
      vt[14] = '{1'b0, 8'h40, 0,  1'b0, 4,   0,  8'h33};
      vt[15] = '{1'b0, 8'h38, 0,  1'b0, 4,   0,  8'h33};
      vt[16] = '{1'b0, 8'h00, 0,  1'b0, 4,   0,  8'h33};

      // Reset values
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst addr_cnt", addr_cnt, 0);
      check("rst busy", busy, 0);
      check("rst disp_on", disp_on, 0);
      check("rst rd_data", rd_data, 8'h00);
      check("rst rd_valid", rd_valid, 0);
      check("rst cmd_err", cmd_err, 0);
      check("rst char_strobe", char_strobe, 0);
      check_blank("rst peek_all");
      bad = 0;
      for (int a = 80; a < 128; a++) begin
         peek(a, v);
         if (v !== 8'h00) bad++;
      end
      check("rst peek_out_of_range", bad, 0);

      // Vector table: one bus write each, then strobe, busy length, AC, display, peek
      prev_ac = 0;
      for (int i = 0; i < 17; i++) begin
         strobe(vt[i].rs, 1'b0, vt[i].d, 3, rdv, rv);
         wait_e2();
         check("vec char_strobe", char_strobe, vt[i].rs);
         if (vt[i].rs) begin
            check("vec char_addr", char_addr, prev_ac);
            check("vec char_data", char_data, vt[i].d);
         end
         busy_len(n);
         check("vec busy_len", n, vt[i].nbusy);
         check("vec addr_cnt", addr_cnt, vt[i].ac);
         check("vec disp_on", disp_on, vt[i].disp);
         peek(vt[i].pa, v);
         check("vec peek", v, vt[i].pv);
         prev_ac = vt[i].ac;
      end
      check("vec cmd_err", cmd_err, 0);

      // Fall detected in the first not-busy cycle after return-home is accepted
      strobe(1'b0, 1'b0, 8'h02, 3, rdv, rv);
      strobe(1'b1, 1'b0, 8'h55, 98, rdv, rv);
      wait_e2();
      check("edge_ok char_strobe", char_strobe, 1);
      check("edge_ok char_addr", char_addr, 0);
      check("edge_ok addr_cnt", addr_cnt, 1);
      check("edge_ok cmd_err", cmd_err, 0);
      busy_len(n);
      check("edge_ok busy_len", n, 4);

      // Fall detected in the last busy cycle is dropped
      strobe(1'b0, 1'b0, 8'h02, 3, rdv, rv);
      strobe(1'b1, 1'b0, 8'h66, 97, rdv, rv);
      wait_e2();
      check("drop char_strobe", char_strobe, 0);
      check("drop cmd_err", cmd_err, 1);
      check("drop addr_cnt", addr_cnt, 0);
      check("drop busy_not_reloaded", busy, 0);
      repeat (5) @(posedge clk);
      #1;
      peek(0, v);
      check("drop peek0", v, 8'h55);

      // Clear after writes, with entry mode set to decrement beforehand
      op(1'b0, 1'b0, 8'h04);
      strobe(1'b0, 1'b0, 8'h01, 3, rdv, rv);
      wait_e2();
      busy_len(n);
      check("clr busy_len", n, 100);
      check("clr addr_cnt", addr_cnt, 0);
      check_blank("clr peek_all");
      op(1'b1, 1'b0, 8'h21);
      check("clr id_restored", addr_cnt, 1);

      // Status read while busy from return-home
      strobe(1'b0, 1'b0, 8'h02, 3, rdv, rv);
      strobe(1'b0, 1'b1, 8'h00, 3, rdv, rv);
      check("stat rd_valid", rv, 1);
      check("stat rd_data", rdv, 8'h80);
      repeat (110) @(posedge clk);
      #1;
      check("stat cmd_err_sticky", cmd_err, 1);

      // Reset while busy
      op(1'b0, 1'b0, 8'h0C);
      op(1'b1, 1'b0, 8'h77);
      strobe(1'b0, 1'b0, 8'h02, 3, rdv, rv);
      wait_e2();
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst busy", busy, 0);
      check("mid_rst addr_cnt", addr_cnt, 0);
      check("mid_rst disp_on", disp_on, 0);
      check("mid_rst cmd_err", cmd_err, 0);
      check("mid_rst rd_data", rd_data, 8'h00);
      check("mid_rst char_addr", char_addr, 0);
      check("mid_rst char_data", char_data, 8'h00);
      check_blank("mid_rst peek_all");
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Randomized traffic against the transaction-level model
      for (int a = 0; a < 80; a++) m_mem[a] = 8'h20;
      m_ac = 0;
      m_id = 1'b1;
      m_disp = 1'b0;
      for (int k = 0; k < 150; k++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 40)      do_op(1'b1, 1'b0, 8'($urandom));
         else if (sel < 70) do_op(1'b0, 1'b0, rnd_cmd());
         else if (sel < 85) do_op(1'b1, 1'b1, 8'($urandom));
         else               do_op(1'b0, 1'b1, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
